tile_dispatcher: RTL and testbench
==================================

// Module: tile_dispatcher
// PURPOSE
//   Schedules tile-scale jobs (per-triangle tile setup) from a single in-order stream onto NUM_PP pixel_processor
//   instances. Keeps tile affinity so each tile's z/color buffer stays in one processor, and load-balances new tiles
//   round-robin. Signals frame completion once all work has been handed off.
// PARAMETERS
//   NUM_PP      4    number of pixel processors served (2..8)
//   PP_IDX_W    2    $clog2(NUM_PP)
//   TILE_X_W    `TILE_COLUMNS_BITS  tile column index width
//   TILE_Y_W    `TILE_ROWS_BITS     tile row index width
//   JOB_W       256  opaque job payload width (abs_pos, deltas, edges, dz, z, color)
// PORTS
//   clk          in   1         clock
//   rst          in   1         synchronous, active-high reset
//   job_vld      in   1         upstream job valid
//   job_rdy      out  1         upstream job ready
//   job_tile_x   in   TILE_X_W  tile column of job
//   job_tile_y   in   TILE_Y_W  tile row of job
//   job_data     in   JOB_W     job payload
//   frame_end    in   1         1-cycle pulse: no more jobs this frame
//   pp_rdy       in   NUM_PP    per-processor rdy_in
//   pp_vld       out  NUM_PP    per-processor vld_in (at most one-hot)
//   pp_tile_x    out  TILE_X_W  shared tile column to processors
//   pp_tile_y    out  TILE_Y_W  shared tile row to processors
//   pp_data      out  JOB_W     shared payload to processors
//   frame_done   out  1         1-cycle pulse: frame drained
//   busy         out  1         state != IDLE or holding register valid
// BEHAVIOUR
//   Reset: state=IDLE, hold_v=0, all bound_v=0, rr_ptr=0, mask=0; pp_vld=0, job_rdy=0 in reset cycle, frame_done=0.
//   Holding reg (1 entry): captures job on job_vld&job_rdy. job_rdy = (~hold_v | dispatch_now) & state!=DRAIN.
//   pp_tile_*/pp_data driven from holding reg (registered; zero latency from hold).
//   Target select (combinational, from hold):
//     - bound hit: some i with bound_v[i] & bound_tile[i]==hold tile -> target=i ONLY; wait for pp_rdy[i]&~mask[i].
//       Never redirect a bound tile.
//     - miss: candidates = pp_rdy & ~mask & ~(PP bound to any tile still held). Prefer unbound PPs, then any
//       candidate; search circularly from rr_ptr.
//       On dispatch rebind bound_tile[t]<=tile, bound_v[t]<=1, rr_ptr<=t+1 mod NUM_PP.
//   pp_vld[t] = hold_v & target_found & pp_rdy[t] & ~mask[t]. Transfer completes at that edge; hold_v cleared
//   unless refilled same cycle.
//   Same-cycle dispatch + accept of the next job is allowed (throughput 1 job/clk while a ready PP exists).
//   mask[t] set for exactly 1 cycle after dispatch to t (covers pp_rdy registered-deassert latency).
//   Tile compare is {tile_y,tile_x} full equality; rebinding a PP to a new tile implies that PP flushes its old tile.
//   FSM: IDLE -(job accepted)-> DISPATCH; DISPATCH -(hold empty, no job)-> IDLE;
//     IDLE/DISPATCH -(frame_end)-> DRAIN;
//     DRAIN -(hold_v==0 & &(pp_rdy&~mask))-> IDLE with frame_done=1 for 1 cycle and all bound_v<=0.
//   frame_end while hold_v=1: held job still dispatched before drain completes. frame_end in DRAIN: ignored.
//   job_vld & frame_end in same cycle: job accepted first, then DRAIN.
//   Reset mid-operation: held job dropped, bindings cleared, no pp_vld in reset cycle or the cycle after.
//   NUM_PP not power of two: rr_ptr wraps at NUM_PP-1 -> 0.
// TESTING (NUM_PP=4)
//   4 jobs tiles (0,0),(1,0),(2,0),(3,0), all pp_rdy=1 -> pp_vld 0001,0010,0100,1000 on consecutive cycles.
//   Job tile (1,0) bound to PP1, pp_rdy=1101 -> job_rdy stalls; no pp_vld until pp_rdy[1]=1, then pp_vld=0010.
//   Dispatch to PP2, pp_rdy[2] held high next cycle -> second job (new tile) skips PP2 (mask), goes to PP3.
//   All bound to tiles A-D, new tile E, pp_rdy=0100, rr_ptr=0 -> PP2 rebound to E, rr_ptr=3.
//   frame_end with hold_v=1, pp_rdy=0000 -> no frame_done; pp_rdy=1111 -> dispatch, then frame_done 1 cycle, bound_v=0.
//   rst=1 with hold_v=1 -> next cycle pp_vld=0, job_rdy=0, busy=0; first job after reset goes to PP0.

Source files
------------

// File: rtl/tile_dispatcher_if.sv
// Handshake bundle between the in-order job stream, the tile dispatcher and
// the pixel processors. The dispatcher sits on the slave modport; the
// environment that feeds jobs and owns the processors sits on the master.

`ifndef TILE_COLUMNS_BITS
`define TILE_COLUMNS_BITS 6
`endif
`ifndef TILE_ROWS_BITS
`define TILE_ROWS_BITS 6
`endif

interface tile_dispatcher_if #(
  parameter int NUM_PP   = 4,
  parameter int TILE_X_W = `TILE_COLUMNS_BITS,
  parameter int TILE_Y_W = `TILE_ROWS_BITS,
  parameter int JOB_W    = 256
);
  // upstream job stream
  logic                job_vld;
  logic                job_rdy;
  logic [TILE_X_W-1:0] job_tile_x;
  logic [TILE_Y_W-1:0] job_tile_y;
  logic [JOB_W-1:0]    job_data;
  logic                frame_end;

  // downstream pixel processors
  logic [NUM_PP-1:0]   pp_rdy;
  logic [NUM_PP-1:0]   pp_vld;
  logic [TILE_X_W-1:0] pp_tile_x;
  logic [TILE_Y_W-1:0] pp_tile_y;
  logic [JOB_W-1:0]    pp_data;

  // status
  logic                frame_done;
  logic                busy;

  modport master (
    output job_vld, job_tile_x, job_tile_y, job_data, frame_end, pp_rdy,
    input  job_rdy, pp_vld, pp_tile_x, pp_tile_y, pp_data, frame_done, busy
  );

  modport slave (
    input  job_vld, job_tile_x, job_tile_y, job_data, frame_end, pp_rdy,
    output job_rdy, pp_vld, pp_tile_x, pp_tile_y, pp_data, frame_done, busy
  );
endinterface

// File: rtl/tile_dispatcher.sv
// Tile dispatcher: takes one in-order job stream and hands each job to one of
// NUM_PP pixel processors. A tile stays with the processor it was first bound
// to (so its z/color buffer never moves); unbound tiles are load-balanced
// round-robin. After frame_end the block drains and pulses frame_done.

`ifndef TILE_COLUMNS_BITS
`define TILE_COLUMNS_BITS 6
`endif
`ifndef TILE_ROWS_BITS
`define TILE_ROWS_BITS 6
`endif

module tile_dispatcher #(
  parameter int NUM_PP   = 4,
  parameter int PP_IDX_W = $clog2(NUM_PP),
  parameter int TILE_X_W = `TILE_COLUMNS_BITS,
  parameter int TILE_Y_W = `TILE_ROWS_BITS,
  parameter int JOB_W    = 256
) (
  input  logic             clk,
  input  logic             rst,
  tile_dispatcher_if.slave bus
);

  localparam int TILE_W = TILE_X_W + TILE_Y_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  // registered state
  state_t              state_reg;
  logic                frame_done_reg;
  logic                out_en_reg;
  logic                hold_v_reg;
  logic [TILE_X_W-1:0] hold_tx_reg;
  logic [TILE_Y_W-1:0] hold_ty_reg;
  logic [JOB_W-1:0]    hold_data_reg;
  logic [NUM_PP-1:0]   bound_v_reg;
  logic [TILE_W-1:0]   bound_tile_reg [NUM_PP];
  logic [PP_IDX_W-1:0] rr_ptr_reg;
  logic [NUM_PP-1:0]   mask_reg;

  // combinational decode
  logic [TILE_W-1:0]   hold_tile;
  logic [NUM_PP-1:0]   avail;
  logic [NUM_PP-1:0]   hit_vec;
  logic [NUM_PP-1:0]   unbound_cand;
  logic [NUM_PP-1:0]   search_vec;
  logic [NUM_PP-1:0]   pp_vld_vec;
  logic                bound_hit;
  logic                target_found;
  logic [PP_IDX_W-1:0] target;
  logic [PP_IDX_W-1:0] rr_next;
  logic                dispatch_now;
  logic                job_rdy_int;
  logic                accept;
  logic                drain_done;

  assign hold_tile = {hold_ty_reg, hold_tx_reg};

  // A processor that was just handed a job may still show rdy for one cycle
  // (its deassert is registered), so it is masked for that cycle.
  assign avail = bus.pp_rdy & ~mask_reg;

  generate
    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_hit
      assign hit_vec[gi] = bound_v_reg[gi] && (bound_tile_reg[gi] == hold_tile);
    end
  endgenerate

  assign bound_hit = |hit_vec;

  // On a miss the only tile held is the current one, which is by definition
  // not bound anywhere, so every available processor is a legal candidate.
  // Unbound processors are preferred so live tile buffers are kept longer.
  assign unbound_cand = avail & ~bound_v_reg;
  assign search_vec   = (|unbound_cand) ? unbound_cand : avail;

  // Target selection: bound tiles go only to their owner; misses search
  // circularly starting at the round-robin pointer.
  always_comb begin
    int idx;
    idx          = 0;
    target       = '0;
    target_found = 1'b0;
    if (bound_hit) begin
      for (int i = 0; i < NUM_PP; i++) begin
        if (hit_vec[i]) begin
          target       = PP_IDX_W'(i);
          target_found = avail[i];
        end
      end
    end else begin
      for (int k = 0; k < NUM_PP; k++) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= NUM_PP) begin
          idx = idx - NUM_PP;
        end
        if (!target_found && search_vec[idx]) begin
          target_found = 1'b1;
          target       = PP_IDX_W'(idx);
        end
      end
    end
  end

  // Explicit wrap so non-power-of-two processor counts cycle correctly.
  assign rr_next = (target == PP_IDX_W'(NUM_PP - 1)) ? '0 : target + 1'b1;

  // Nothing leaves or enters while reset is asserted or in the cycle after.
  assign dispatch_now = out_en_reg & ~rst & hold_v_reg & target_found;
  assign job_rdy_int  = out_en_reg & ~rst & (~hold_v_reg | dispatch_now) &
                        (state_reg != DRAIN);
  assign accept       = bus.job_vld & job_rdy_int;
  assign drain_done   = (state_reg == DRAIN) & ~hold_v_reg & (&avail);

  generate
    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_vld
      assign pp_vld_vec[gi] = dispatch_now && (target == PP_IDX_W'(gi));
    end
  endgenerate

  assign bus.job_rdy    = job_rdy_int;
  assign bus.pp_vld     = pp_vld_vec;
  assign bus.pp_tile_x  = hold_tx_reg;
  assign bus.pp_tile_y  = hold_ty_reg;
  assign bus.pp_data    = hold_data_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.busy       = (state_reg != IDLE) | hold_v_reg;

  // Frame-level control: track activity, drain on frame_end, pulse frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.frame_end) begin
            state_reg <= DRAIN;
          end else if (accept) begin
            state_reg <= DISPATCH;
          end
        end
        DISPATCH: begin
          if (bus.frame_end) begin
            state_reg <= DRAIN;
          end else if (!accept && (!hold_v_reg || dispatch_now)) begin
            state_reg <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_reg      <= IDLE;
            frame_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Holding-register occupancy, round-robin pointer, one-cycle dispatch mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_reg <= 1'b0;
      hold_v_reg <= 1'b0;
      rr_ptr_reg <= '0;
      mask_reg   <= '0;
    end else begin
      out_en_reg <= 1'b1;
      mask_reg   <= pp_vld_vec;
      if (dispatch_now && !bound_hit) begin
        rr_ptr_reg <= rr_next;
      end
      if (accept) begin
        hold_v_reg <= 1'b1;
      end else if (dispatch_now) begin
        hold_v_reg <= 1'b0;
      end
    end
  end

  // Holding-register payload; only meaningful while hold_v_reg is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_tx_reg   <= bus.job_tile_x;
      hold_ty_reg   <= bus.job_tile_y;
      hold_data_reg <= bus.job_data;
    end
  end

  // Tile bindings: a miss dispatch rebinds the target (it flushes its old
  // tile); a completed drain forgets every binding for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      bound_v_reg <= '0;
      for (int i = 0; i < NUM_PP; i++) begin
        bound_tile_reg[i] <= '0;
      end
    end else if (drain_done) begin
      bound_v_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_PP; i++) begin
        if (pp_vld_vec[i] && !bound_hit) begin
          bound_v_reg[i]    <= 1'b1;
          bound_tile_reg[i] <= hold_tile;
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_dispatcher.sv
// Scoreboard bench for tile_dispatcher (NUM_PP=4): directed jobs push their
// hand-computed target processor into a queue; a negedge monitor pops and
// compares every dispatch.

module tb_tile_dispatcher;

  localparam int NUM_PP = 4;
  localparam int TX_W   = 6;
  localparam int TY_W   = 6;
  localparam int JOB_W  = 256;

  typedef struct packed {
    logic [1:0]       pp;
    logic [TY_W-1:0]  ty;
    logic [TX_W-1:0]  tx;
    logic [JOB_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   disp_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tile_dispatcher_if #(.NUM_PP(NUM_PP), .TILE_X_W(TX_W), .TILE_Y_W(TY_W), .JOB_W(JOB_W)) bus ();

  tile_dispatcher #(
    .NUM_PP(NUM_PP), .PP_IDX_W(2), .TILE_X_W(TX_W), .TILE_Y_W(TY_W), .JOB_W(JOB_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [JOB_W-1:0] mk_data(input int n);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(n);
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  // Offer one job and hold it until accepted; returns 1 ns after the accept edge.
  task automatic send_job(input int tx, input int ty, input int n, input int pp,
                          input bit expect_it, input bit fe);
    exp_t e;
    int   w;
    w = 0;
    bus.job_vld    = 1'b1;
    bus.job_tile_x = TX_W'(tx);
    bus.job_tile_y = TY_W'(ty);
    bus.job_data   = mk_data(n);
    bus.frame_end  = fe;
    if (expect_it) begin
      e.pp = 2'(pp); e.tx = TX_W'(tx); e.ty = TY_W'(ty); e.data = mk_data(n);
      exp_q.push_back(e);
    end
    do begin
      @(negedge clk);
      w++;
    end while (!bus.job_rdy && w < 100);
    if (!bus.job_rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout job tile=(%0d,%0d) job_rdy=0 required=1", tx, ty);
    end
    @(posedge clk); #1;
    bus.job_vld   = 1'b0;
    bus.frame_end = 1'b0;
  endtask

  // Wait for busy to drop, then one more cycle so the dispatch mask clears.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 100);
    if (bus.busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=1 required=0");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 50);
    chk("frame_done_seen", 32'(bus.frame_done), 32'd1);
    chk("drained_before_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("frame_done_pulse_width", 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: every dispatch must be one-hot and match the next expected job.
  initial begin
    exp_t e;
    logic [NUM_PP-1:0] expv;
    forever begin
      @(negedge clk);
      if (bus.pp_vld != '0) begin
        disp_cyc.push_back(cyc);
        checks++;
        if ($countones(bus.pp_vld) != 1) begin
          errors++;
          $display("FAIL onehot pp_vld=%b required one-hot", bus.pp_vld);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dispatch pp_vld=%b tile=(%0d,%0d) required no dispatch",
                   bus.pp_vld, bus.pp_tile_x, bus.pp_tile_y);
        end else begin
          e = exp_q.pop_front();
          expv = 4'b0001 << e.pp;
          if (bus.pp_vld !== expv || bus.pp_tile_x !== e.tx || bus.pp_tile_y !== e.ty ||
              bus.pp_data !== e.data) begin
            errors++;
            $display("FAIL dispatch actual pp_vld=%b tile=(%0d,%0d) data=%h required pp_vld=%b tile=(%0d,%0d) data=%h",
                     bus.pp_vld, bus.pp_tile_x, bus.pp_tile_y, bus.pp_data[31:0],
                     expv, e.tx, e.ty, e.data[31:0]);
          end else begin
            $display("dispatch pp_vld=%b tile=(%0d,%0d) cycle=%0d ok",
                     bus.pp_vld, bus.pp_tile_x, bus.pp_tile_y, cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.job_vld    = 1'b0;
    bus.job_tile_x = '0;
    bus.job_tile_y = '0;
    bus.job_data   = '0;
    bus.frame_end  = 1'b0;
    bus.pp_rdy     = '0;
    rst            = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pp_vld", 32'(bus.pp_vld), 32'd0);
    chk("rst_job_rdy", 32'(bus.job_rdy), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_job_rdy", 32'(bus.job_rdy), 32'd0);
    @(negedge clk);
    chk("idle_job_rdy", 32'(bus.job_rdy), 32'd1);
    @(posedge clk); #1;

    // Four new tiles, all ready: round-robin 0,1,2,3 on consecutive cycles
    bus.pp_rdy = 4'b1111;
    disp_cyc.delete();
    send_job(0, 0, 1, 0, 1'b1, 1'b0);
    send_job(1, 0, 2, 1, 1'b1, 1'b0);
    send_job(2, 0, 3, 2, 1'b1, 1'b0);
    send_job(3, 0, 4, 3, 1'b1, 1'b0);
    wait_idle();
    chk("rr_dispatch_count", 32'(disp_cyc.size()), 32'd4);
    if (disp_cyc.size() == 4) chk("rr_back_to_back", 32'(disp_cyc[3] - disp_cyc[0]), 32'd3);

    // All bound, new tile E, only PP2 ready, rr_ptr=0 -> PP2, rr_ptr becomes 3
    bus.pp_rdy = 4'b0100;
    send_job(5, 1, 5, 2, 1'b1, 1'b0);
    wait_idle();
    // rr_ptr=3 shows up as the next all-bound miss landing on PP3
    bus.pp_rdy = 4'b1111;
    send_job(6, 1, 6, 3, 1'b1, 1'b0);
    wait_idle();

    // Tile (1,0) bound to PP1 which is not ready: stall, then PP1
    bus.pp_rdy = 4'b1101;
    fork
      begin
        send_job(1, 0, 7, 1, 1'b1, 1'b0);
        send_job(0, 0, 8, 0, 1'b1, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        chk("bound_stall_job_rdy", 32'(bus.job_rdy), 32'd0);
        chk("bound_stall_pp_vld", 32'(bus.pp_vld), 32'd0);
        @(negedge clk);
        chk("bound_stall_job_rdy2", 32'(bus.job_rdy), 32'd0);
        chk("bound_stall_pp_vld2", 32'(bus.pp_vld), 32'd0);
        @(posedge clk); #1;
        bus.pp_rdy = 4'b1111;
      end
    join
    wait_idle();

    // Dispatch to PP2 with its rdy still high: next new tile skips PP2 -> PP3
    bus.pp_rdy = 4'b1100;
    send_job(7, 2, 9, 2, 1'b1, 1'b0);
    send_job(8, 2, 10, 3, 1'b1, 1'b0);
    wait_idle();

    // Only PP2 ready: the second job must wait out the mask cycle
    bus.pp_rdy = 4'b0100;
    disp_cyc.delete();
    send_job(9, 2, 11, 2, 1'b1, 1'b0);
    send_job(10, 2, 12, 2, 1'b1, 1'b0);
    wait_idle();
    chk("mask_dispatch_count", 32'(disp_cyc.size()), 32'd2);
    if (disp_cyc.size() == 2) chk("mask_gap", 32'(disp_cyc[1] - disp_cyc[0]), 32'd2);

    // frame_end while a job is held and nothing is ready: no frame_done yet
    bus.pp_rdy = 4'b0000;
    send_job(0, 0, 13, 0, 1'b1, 1'b0);
    bus.frame_end = 1'b1;
    @(posedge clk); #1;
    bus.frame_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_no_frame_done", 32'(bus.frame_done), 32'd0);
      chk("drain_job_rdy", 32'(bus.job_rdy), 32'd0);
      chk("drain_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clk); #1;
    bus.pp_rdy = 4'b1111;
    wait_frame_done();

    // Job and frame_end together; bindings were cleared, so tile (1,0) is a
    // fresh tile and goes round-robin from rr_ptr=3 to PP3, not to old PP1
    send_job(1, 0, 14, 3, 1'b1, 1'b1);
    wait_frame_done();
    wait_idle();

    // Reset with a job held: job dropped, quiet cycle, then PP0 first
    bus.pp_rdy = 4'b0000;
    send_job(2, 2, 15, 0, 1'b0, 1'b0);
    rst = 1'b1;
    bus.pp_rdy = 4'b1111;
    @(negedge clk);
    chk("midrst_pp_vld", 32'(bus.pp_vld), 32'd0);
    chk("midrst_job_rdy", 32'(bus.job_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_pp_vld", 32'(bus.pp_vld), 32'd0);
    chk("after_rst_job_rdy", 32'(bus.job_rdy), 32'd0);
    chk("after_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    send_job(3, 3, 16, 0, 1'b1, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
